mem_arbiter: RTL

- Shares one slow_memory port (read/write, 128-bit line, 28-bit line address, ready) between the I-cache and D-cache miss/writeback ports of CHIP.
- Latches the granted request and drives the memory until mem_ready, then returns ready and data to that requester only.
- Used in the single-memory (L2Cache) configuration, between the caches and the slow memory or L2.

---
 rtl/mem_arbiter_pkg.sv | 42 ++++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_req_latch.sv | 24 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the I/D cache to slow-memory arbiter.
// Line address is bits [31:4] of the byte address; one line is 128 bits.
package mem_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // A request with both read and write set is treated as a write.
  function automatic mem_req_t make_req(
    input logic              rd,
    input logic              wr,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    mem_req_t r;
    r.read  = rd & ~wr;
    r.write = wr;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-side, D-side and memory-side signals of the arbiter.
// master: the arbiter's view; slave: the caches and memory around it.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              I_read;
  logic              I_write;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_wdata;
  logic [DATA_W-1:0] I_rdata;
  logic              I_ready;

  logic              D_read;
  logic              D_write;
  logic [ADDR_W-1:0] D_addr;
  logic [DATA_W-1:0] D_wdata;
  logic [DATA_W-1:0] D_rdata;
  logic              D_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  modport master (
    input  I_read, I_write, I_addr, I_wdata,
    output I_rdata, I_ready,
    input  D_read, D_write, D_addr, D_wdata,
    output D_rdata, D_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport slave (
    output I_read, I_write, I_addr, I_wdata,
    input  I_rdata, I_ready,
    output D_read, D_write, D_addr, D_wdata,
    input  D_rdata, D_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy
  );

endinterface

// File: rtl/mem_req_latch.sv
// Holds the granted request so the memory sees stable signals
// regardless of what the requester does during service.
module mem_req_latch
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t d,
  output mem_req_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow-memory line port between
// the I-cache and D-cache, with a one-cycle gap between services.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mem_arbiter_if.master bus
);

  // Seeding the history with the loser makes the first tie go to D_FIRST.
  localparam side_t RST_LAST = D_FIRST ? SIDE_I : SIDE_D;

  arb_state_t state;
  arb_state_t state_nx;
  side_t      last_grant;
  side_t      last_nx;

  logic     i_pend;
  logic     d_pend;
  logic     pick_d;
  logic     load;
  logic     clear;
  logic     serve_i;
  logic     serve_d;
  mem_req_t req_d;
  mem_req_t req_q;

  assign i_pend = bus.I_read | bus.I_write;
  assign d_pend = bus.D_read | bus.D_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= RST_LAST;
    end else begin
      state      <= state_nx;
      last_grant <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last_grant;
    pick_d   = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_pend | d_pend) begin
          pick_d   = d_pend & (~i_pend | (last_grant == SIDE_I));
          load     = 1'b1;
          state_nx = pick_d ? SERVE_D : SERVE_I;
          last_nx  = pick_d ? SIDE_D : SIDE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_ready) begin
          clear    = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign req_d = pick_d
    ? make_req(bus.D_read, bus.D_write, bus.D_addr, bus.D_wdata)
    : make_req(bus.I_read, bus.I_write, bus.I_addr, bus.I_wdata);

  mem_req_latch u_latch (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (clear),
    .d     (req_d),
    .q     (req_q)
  );

  assign bus.mem_read  = req_q.read;
  assign bus.mem_write = req_q.write;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;

  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);

  assign bus.I_ready = serve_i & bus.mem_ready;
  assign bus.D_ready = serve_d & bus.mem_ready;
  assign bus.I_rdata = serve_i ? bus.mem_rdata : '0;
  assign bus.D_rdata = serve_d ? bus.mem_rdata : '0;

  assign bus.busy = (state != IDLE);

endmodule
